ex_muldiv: RTL

- Iterative RV64M multiply/divide unit attached to the execute stage, alongside the single-cycle ALU.
- Accepts one M-extension operation, iterates over several cycles and returns the rd write-back value.
- Raises a stall request so the pipeline holds the instruction in EX until the result is delivered.
- Generalises the execute datapath in XLEN and multiplier radix; this is the first multi-cycle execute resource.

---
 rtl/ex_muldiv_pkg.sv | 58 +++++
 rtl/muldiv_core.sv | 81 ++++++++
 rtl/ex_muldiv.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit.
// Holds the M-extension op codes, the FSM state encoding and the op decoder.
// Pure declarations: no timing, no flow control.
package muldiv_defs;

    localparam logic [3:0] MD_MUL    = 4'd0;
    localparam logic [3:0] MD_MULH   = 4'd1;
    localparam logic [3:0] MD_MULHSU = 4'd2;
    localparam logic [3:0] MD_MULHU  = 4'd3;
    localparam logic [3:0] MD_DIV    = 4'd4;
    localparam logic [3:0] MD_DIVU   = 4'd5;
    localparam logic [3:0] MD_REM    = 4'd6;
    localparam logic [3:0] MD_REMU   = 4'd7;
    localparam logic [3:0] MD_MULW   = 4'd8;
    localparam logic [3:0] MD_DIVW   = 4'd9;
    localparam logic [3:0] MD_DIVUW  = 4'd10;
    localparam logic [3:0] MD_REMW   = 4'd11;
    localparam logic [3:0] MD_REMUW  = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } md_state_t;

    // Decoded view of an op code.
    typedef struct packed {
        logic is_div;   // divide family (quotient or remainder)
        logic is_rem;   // remainder result
        logic is_high;  // upper half of the product
        logic is_w;     // 32-bit word op
        logic a_sgn;    // rs1 treated as signed
        logic b_sgn;    // rs2 treated as signed
    } md_dec_t;

    // Unused codes decode as MUL, whose low product bits ignore signedness.
    function automatic md_dec_t md_decode(input logic [3:0] op);
        md_dec_t d;
        d = '0;
        case (op)
            MD_MULH:   begin d.is_high = 1'b1; d.a_sgn = 1'b1; d.b_sgn = 1'b1; end
            MD_MULHSU: begin d.is_high = 1'b1; d.a_sgn = 1'b1; end
            MD_MULHU:  begin d.is_high = 1'b1; end
            MD_DIV:    begin d.is_div = 1'b1; d.a_sgn = 1'b1; d.b_sgn = 1'b1; end
            MD_DIVU:   begin d.is_div = 1'b1; end
            MD_REM:    begin d.is_div = 1'b1; d.is_rem = 1'b1; d.a_sgn = 1'b1; d.b_sgn = 1'b1; end
            MD_REMU:   begin d.is_div = 1'b1; d.is_rem = 1'b1; end
            MD_MULW:   begin d.is_w = 1'b1; end
            MD_DIVW:   begin d.is_div = 1'b1; d.is_w = 1'b1; d.a_sgn = 1'b1; d.b_sgn = 1'b1; end
            MD_DIVUW:  begin d.is_div = 1'b1; d.is_w = 1'b1; end
            MD_REMW:   begin d.is_div = 1'b1; d.is_rem = 1'b1; d.is_w = 1'b1; d.a_sgn = 1'b1; d.b_sgn = 1'b1; end
            MD_REMUW:  begin d.is_div = 1'b1; d.is_rem = 1'b1; d.is_w = 1'b1; end
            default:   ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative unsigned datapath: radix-2^MUL_STEP shift-add multiply, restoring divide.
// Latency: N step cycles after load (N = XLEN/MUL_STEP, 32/MUL_STEP, XLEN or 32).
// No flow control: the owner pulses load, then raises step until last is seen.
module muldiv_core #(
    parameter int XLEN     = 64,
    parameter int MUL_STEP = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic              div_mode,
    input  logic              w_mode,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic              last,
    output logic [2*XLEN-1:0] acc
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0] N_MUL  = CW'(XLEN / MUL_STEP);
    localparam logic [CW-1:0] N_MULW = CW'(32 / MUL_STEP);
    localparam logic [CW-1:0] N_DIV  = CW'(XLEN);
    localparam logic [CW-1:0] N_DIVW = CW'(32);

    // Multiply: acc = {partial sum, multiplier}; divide: acc = {remainder, dividend/quotient}.
    logic [2*XLEN-1:0]        acc_q;
    logic [XLEN-1:0]          opb_q;
    logic [CW-1:0]            cnt_q;
    logic                     div_q;

    logic [XLEN+MUL_STEP-1:0] partial;
    logic [XLEN+MUL_STEP-1:0] msum;
    logic [2*XLEN-1:0]        mul_next;
    logic [XLEN:0]            upper;
    logic [XLEN:0]            diff;
    logic [2*XLEN-1:0]        div_next;
    logic [2*XLEN-1:0]        acc_init;
    logic [CW-1:0]            cnt_init;

    // One iteration of each algorithm plus the load values.
    always_comb begin
        partial  = {{MUL_STEP{1'b0}}, opb_q} * {{XLEN{1'b0}}, acc_q[MUL_STEP-1:0]};
        msum     = {{MUL_STEP{1'b0}}, acc_q[2*XLEN-1:XLEN]} + partial;
        mul_next = {msum, acc_q[XLEN-1:MUL_STEP]};

        upper    = acc_q[2*XLEN-1:XLEN-1];
        diff     = upper - {1'b0, opb_q};
        div_next = diff[XLEN] ? {upper[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                              : {diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};

        // Word divides run 32 iterations, so the dividend must start at the top.
        if (div_mode && w_mode) acc_init = {{XLEN{1'b0}}, a << (XLEN - 32)};
        else                    acc_init = {{XLEN{1'b0}}, a};

        if (div_mode) cnt_init = w_mode ? N_DIVW : N_DIV;
        else          cnt_init = w_mode ? N_MULW : N_MUL;
    end

    // Operand/accumulator registers: load on accept, advance while stepping.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            opb_q <= '0;
            cnt_q <= '0;
            div_q <= 1'b0;
        end else if (load) begin
            acc_q <= acc_init;
            opb_q <= b;
            cnt_q <= cnt_init;
            div_q <= div_mode;
        end else if (step) begin
            acc_q <= div_q ? div_next : mul_next;
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign last = (cnt_q == CW'(1));
    assign acc  = acc_q;

endmodule

// File: rtl/ex_muldiv.sv
// RV64M multiply/divide unit in EX: op accepted from IDLE, result presented in DONE.
// Latency: N+1 cycles from accept (1 cycle for divide-by-zero / signed overflow).
// Holds EX via stall_req_o until done; DONE persists while hold_i, flush_i kills it.
module ex_muldiv
    import muldiv_defs::*;
#(
    parameter int XLEN     = 64,
    parameter int MUL_STEP = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    input  logic            hold_i,
    output logic            busy_o,
    output logic            stall_req_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_addr_o
);

    md_state_t         state, nxt;
    md_dec_t           dec;
    logic              use_w;
    logic [XLEN-1:0]   a_x, b_x, a_mag, b_mag, spec_val;
    logic              a_neg, b_neg, a_min, div0, ovf, special, accept, res_neg;

    logic              div_q, rem_q, high_q, w_q, neg_q, special_q;
    logic [XLEN-1:0]   spec_q;
    logic [4:0]        rd_q;

    logic              core_last;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   r_sel, res_raw, res, hi_neg;

    // Decode the op in EX, extend operands, take magnitudes and spot special cases.
    always_comb begin
        dec   = md_decode(op_i);
        use_w = dec.is_w && (XLEN == 64);
        if (use_w) begin
            if (dec.a_sgn) a_x = XLEN'($signed(op1_i[31:0]));
            else           a_x = XLEN'(op1_i[31:0]);
            if (dec.b_sgn) b_x = XLEN'($signed(op2_i[31:0]));
            else           b_x = XLEN'(op2_i[31:0]);
            a_min = (op1_i[31:0] == 32'h8000_0000);
        end else begin
            a_x   = op1_i;
            b_x   = op2_i;
            a_min = (op1_i == {1'b1, {(XLEN-1){1'b0}}});
        end
        a_neg   = dec.a_sgn && a_x[XLEN-1];
        b_neg   = dec.b_sgn && b_x[XLEN-1];
        a_mag   = a_neg ? -a_x : a_x;
        b_mag   = b_neg ? -b_x : b_x;
        div0    = dec.is_div && (b_x == '0);
        ovf     = dec.is_div && dec.a_sgn && a_min && (b_x == '1);
        special = div0 || ovf;
        if (div0) spec_val = dec.is_rem ? a_x : '1;
        else      spec_val = dec.is_rem ? '0 : a_x;
        // Remainder follows the dividend; quotient and high product follow the operand signs.
        if (dec.is_div) res_neg = dec.is_rem ? a_neg : (a_neg ^ b_neg);
        else            res_neg = dec.is_high && (a_neg ^ b_neg);
        accept = (state == ST_IDLE) && start_i && !flush_i;
    end

    // Capture op attributes, special-case result and rd when an op is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q     <= 1'b0;
            rem_q     <= 1'b0;
            high_q    <= 1'b0;
            w_q       <= 1'b0;
            neg_q     <= 1'b0;
            special_q <= 1'b0;
            spec_q    <= '0;
            rd_q      <= '0;
        end else if (accept) begin
            div_q     <= dec.is_div;
            rem_q     <= dec.is_rem;
            high_q    <= dec.is_high;
            w_q       <= use_w;
            neg_q     <= res_neg;
            special_q <= special;
            spec_q    <= spec_val;
            rd_q      <= rd_addr_i;
        end
    end

    muldiv_core #(
        .XLEN     (XLEN),
        .MUL_STEP (MUL_STEP)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (accept && !special),
        .step     ((state == ST_CALC) && !flush_i),
        .div_mode (dec.is_div),
        .w_mode   (use_w),
        .a        (a_mag),
        .b        (b_mag),
        .last     (core_last),
        .acc      (acc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= nxt;
    end

    // Next state: only IDLE accepts, so an op held in EX during DONE never reruns.
    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE: if (accept) nxt = special ? ST_DONE : ST_CALC;
            ST_CALC: begin
                if (flush_i)        nxt = ST_IDLE;
                else if (core_last) nxt = ST_DONE;
            end
            ST_DONE: begin
                if (flush_i || !hold_i) nxt = ST_IDLE;
            end
            default: nxt = ST_IDLE;
        endcase
    end

    // Sign fix-up and width selection; the core is frozen outside CALC so this is stable in DONE.
    always_comb begin
        // High half of the negated 128-bit product: ~hi plus the borrow out of the low half.
        hi_neg = ~acc[2*XLEN-1:XLEN] + XLEN'(acc[XLEN-1:0] == '0);
        r_sel  = rem_q ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
        if (special_q)   res_raw = spec_q;
        else if (div_q)  res_raw = neg_q ? -r_sel : r_sel;
        else if (high_q) res_raw = neg_q ? hi_neg : acc[2*XLEN-1:XLEN];
        else if (w_q)    res_raw = XLEN'(acc[XLEN-1 -: 32]);
        else             res_raw = acc[XLEN-1:0];
        if (w_q) res = XLEN'($signed(res_raw[31:0]));
        else     res = res_raw;
    end

    // Outputs: a flush in DONE suppresses the result in that same cycle.
    always_comb begin
        busy_o      = (state != ST_IDLE);
        done_o      = (state == ST_DONE) && !flush_i;
        result_o    = done_o ? res : '0;
        stall_req_o = start_i && !done_o;
        rd_addr_o   = rd_q;
    end

endmodule
